cond_logic: RTL and testbench
=============================

# cond_logic

Conditional-execution unit that consumes the N/Z/C/V flags produced by the flag-generating ALU. It holds the architectural NZCV register, evaluates the 4-bit ARM condition field against the stored flags, and gates the PC, register-file and memory write enables of the current instruction. It sits between the control decoder and the datapath and supports both single-cycle and multicycle sequencing.

## Interface
- `REG_CONDEX`, default 0: 0 = single-cycle, condition result used combinationally; 1 = multicycle, condition result latched at instruction start and held.

- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cond`  in  4  instruction condition field [31:28].
- `alu_flags`  in  4  {n,z,c,v} from the ALU for the current instruction.
- `flag_w`  in  2  decoder flag-write request: [1] = update N,Z; [0] = update C,V.
- `pcs`  in  1  decoder request to write PC.
- `reg_w`  in  1  decoder request to write the register file.
- `mem_w`  in  1  decoder request to write memory.
- `no_write`  in  1  compare-class instruction: suppresses the register write.
- `instr_start`  in  1  pulse on the first execute cycle of an instruction. Used only when REG_CONDEX=1.
- `pc_src`  out  1  gated PC write.
- `reg_write`  out  1  gated register-file write.
- `mem_write`  out  1  gated memory write.
- `flags`  out  4  current stored {n,z,c,v}.
- `cond_ex`  out  1  condition passed.

## Operation
- Condition decode uses the stored flags N,Z,C,V:
  - 0000 EQ: Z.
  - 0001 NE: !Z.
  - 0010 CS: C.
  - 0011 CC: !C.
  - 0100 MI: N.
  - 0101 PL: !N.
  - 0110 VS: V.
  - 0111 VC: !V.
  - 1000 HI: C & !Z.
  - 1001 LS: !C | Z.
  - 1010 GE: N==V.
  - 1011 LT: N!=V.
  - 1100 GT: !Z & (N==V).
  - 1101 LE: Z | (N!=V).
  - 1110 AL: 1.
  - 1111 reserved: 0. The instruction is squashed.
- `cond_ex`:
  - REG_CONDEX=0: the combinational decode result.
  - REG_CONDEX=1: `condex_q`. It is loaded with the decode result on a clock edge where `instr_start`=1 and held otherwise. In the `instr_start` cycle itself, `cond_ex` shows the live decode result (bypass), so the first cycle is gated correctly.
- Gating:
  - `pc_src` = `pcs` & `cond_ex`.
  - `reg_write` = `reg_w` & `cond_ex` & !`no_write`.
  - `mem_write` = `mem_w` & `cond_ex`.
- Flag update on the clock edge: effective write = `flag_w` & {2{`cond_ex`}}.
  - If [1]: N,Z <= `alu_flags`[3:2].
  - If [0]: C,V <= `alu_flags`[1:0].
  - The two halves are independent. Logical ops with S set request only [1].
- The condition is always evaluated against the flags *before* the same-cycle update. A flag-setting conditional instruction reads the old flags and writes the new ones at the end of the cycle.

## Timing
- Reset (`reset_n`=0, asynchronous): NZCV = 0000 and `condex_q` = 0.
  - `flags` = 0000.
  - In single-cycle mode, outputs then follow inputs combinationally. With flags 0000, EQ fails and NE passes.
  - With REG_CONDEX=1 and no `instr_start`, all gated outputs are 0 until the first `instr_start`.
- Latency:
  - Gated enables: 0 cycles (combinational).
  - Flag update: visible on `flags` 1 cycle after the write edge.
- Back-to-back: instruction k+1 sees the flags written by instruction k.
- Multicycle: `cond_ex` stays constant across all cycles of one instruction. Changes on `cond` or the flags mid-instruction have no effect until the next `instr_start`.
- `instr_start` asserted together with `flag_w`: the condition is evaluated on the old flags, and the latch and the flag write occur on the same edge.
- Reset deasserted mid-instruction: state restarts from the reset values. No partial flag write occurs.

## Structure
- Shared package `arm_pkg`:
  - `cond_e` enum (EQ..AL, NV = 4'b1111).
  - Flag index constants `FLAG_N` = 3, `FLAG_Z` = 2, `FLAG_C` = 1, `FLAG_V` = 0.
  - `flags_t` packed struct {n,z,c,v}.
- One sub-module, `cond_check`: a purely combinational decoder (`cond`, `flags` → `pass`), reusable by the branch predictor and the test model.
- Top level holds the NZCV register, the optional `condex_q` register and the gating logic.

## Test plan
- Reset, then `cond`=1110, `reg_w`=1 → `reg_write`=1 and `flags`=0000. Then `cond`=0000 → `reg_write`=0.
- `flag_w`=11, `cond`=1110, `alu_flags`=0100 (result 0) → next cycle `flags`=0100. Then `cond`=0000, `mem_w`=1 → `mem_write`=1. Then `cond`=0001 → `mem_write`=0.
- Flags 1001 (N=1, V=1), `cond`=1010 (GE) → `cond_ex`=1. Flags 1000 → `cond_ex`=0, and with `cond`=1011 (LT) → `cond_ex`=1. Flags 0010 with HI → 1, flags 0110 with LS → 1.
- Failed condition with `flag_w`=11 and `alu_flags`=1111 → `flags` unchanged. `flag_w`=10 with a passing condition → only N,Z change, C,V keep their prior value.
- `no_write`=1 (CMP), `reg_w`=1, `cond`=1110 → `reg_write`=0 while the flags still update. `cond`=1111 → all gated outputs 0.
- REG_CONDEX=1: EQ latched true at `instr_start` with Z=1. The instruction's own `flag_w`=10 clears Z next cycle → `pc_src` stays 1 for the remaining cycles of the instruction. The next `instr_start` with EQ → `pc_src`=0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM condition-code types: condition field encoding, NZCV bit positions
// and the packed flag struct used by the condition unit and its consumers.
package arm_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/cond_logic_cond_check.sv
// Purely combinational ARM condition decoder: evaluates a 4-bit condition field
// against a set of NZCV flags. Kept standalone so other units can reuse it.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    flags_t w_f;

    assign w_f = flags_t'(flags);

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            EQ:      pass = w_f.z;
            NE:      pass = !w_f.z;
            CS:      pass = w_f.c;
            CC:      pass = !w_f.c;
            MI:      pass = w_f.n;
            PL:      pass = !w_f.n;
            VS:      pass = w_f.v;
            VC:      pass = !w_f.v;
            HI:      pass = w_f.c && !w_f.z;
            LS:      pass = !w_f.c || w_f.z;
            GE:      pass = (w_f.n == w_f.v);
            LT:      pass = (w_f.n != w_f.v);
            GT:      pass = !w_f.z && (w_f.n == w_f.v);
            LE:      pass = w_f.z || (w_f.n != w_f.v);
            AL:      pass = 1'b1;
            // Reserved encoding squashes the instruction.
            NV:      pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds the NZCV register, evaluates the condition
// field on the pre-update flags and gates the PC, register and memory writes.
module cond_logic
    import arm_pkg::*;
#(
    parameter bit REG_CONDEX = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    input  logic       instr_start,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic [3:0] flags,
    output logic       cond_ex
);

    flags_t     r_flags;
    logic       r_condex_q;
    logic       w_pass;
    logic       w_cond_ex;
    logic [1:0] w_flag_we;

    cond_check u_cond_check (
        .cond  (cond),
        .flags (r_flags),
        .pass  (w_pass)
    );

    // Captures the condition once per instruction; unused (and trimmed) in single-cycle mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_condex_q <= 1'b0;
        end else if (instr_start) begin
            r_condex_q <= w_pass;
        end
    end

    // The start cycle bypasses the latch so the first execute cycle is gated on the live result.
    assign w_cond_ex = (REG_CONDEX && !instr_start) ? r_condex_q : w_pass;

    assign w_flag_we = flag_w & {2{w_cond_ex}};

    // N/Z and C/V halves update independently so logical ops can preserve C and V.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags <= '0;
        end else begin
            if (w_flag_we[1]) begin
                r_flags.n <= alu_flags[FLAG_N];
                r_flags.z <= alu_flags[FLAG_Z];
            end
            if (w_flag_we[0]) begin
                r_flags.c <= alu_flags[FLAG_C];
                r_flags.v <= alu_flags[FLAG_V];
            end
        end
    end

    assign pc_src    = pcs & w_cond_ex;
    assign reg_write = reg_w & w_cond_ex & !no_write;
    assign mem_write = mem_w & w_cond_ex;
    assign flags     = r_flags;
    assign cond_ex   = w_cond_ex;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: runs a single-cycle and a multicycle
// instance side by side against a scoreboard fed by a small reference model.
module tb_cond_logic;
    import arm_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] cond, alu_flags;
    logic [1:0] flag_w;
    logic       pcs, reg_w, mem_w, no_write, instr_start;

    logic       pc0, rw0, mw0, cx0, pc1, rw1, mw1, cx1;
    logic [3:0] fl0, fl1;

    typedef struct packed {
        logic       pc;
        logic       rw;
        logic       mw;
        logic [3:0] fl;
        logic       cx;
    } obs_t;

    typedef struct packed {
        logic [3:0] c;
        logic [3:0] a;
        logic [1:0] fw;
        logic       p;
        logic       r;
        logic       m;
        logic       nw;
        logic       st;
    } stim_t;

    obs_t obs0, obs1;
    obs_t expq[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0] mf0, mf1;
    logic       mq1;

    always #5 clk = ~clk;

    cond_logic #(.REG_CONDEX(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .cond(cond), .alu_flags(alu_flags),
        .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w),
        .no_write(no_write), .instr_start(instr_start),
        .pc_src(pc0), .reg_write(rw0), .mem_write(mw0), .flags(fl0), .cond_ex(cx0)
    );

    cond_logic #(.REG_CONDEX(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .cond(cond), .alu_flags(alu_flags),
        .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w),
        .no_write(no_write), .instr_start(instr_start),
        .pc_src(pc1), .reg_write(rw1), .mem_write(mw1), .flags(fl1), .cond_ex(cx1)
    );

    assign obs0 = {pc0, rw0, mw0, fl0, cx0};
    assign obs1 = {pc1, rw1, mw1, fl1, cx1};

    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return ~z;
            4'h2: return cy;
            4'h3: return ~cy;
            4'h4: return n;
            4'h5: return ~n;
            4'h6: return v;
            4'h7: return ~v;
            4'h8: return cy & ~z;
            4'h9: return ~cy | z;
            4'hA: return ~(n ^ v);
            4'hB: return n ^ v;
            4'hC: return ~z & ~(n ^ v);
            4'hD: return z | (n ^ v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic obs_t mk(input logic [3:0] f, input logic c);
        mk = {pcs & c, reg_w & c & ~no_write, mem_w & c, f, c};
    endfunction

    task automatic drive(input stim_t s);
        cond = s.c; alu_flags = s.a; flag_w = s.fw;
        pcs = s.p; reg_w = s.r; mem_w = s.m; no_write = s.nw; instr_start = s.st;
    endtask

    task automatic push_expect();
        logic c0, c1;
        c0 = ref_pass(cond, mf0);
        c1 = instr_start ? ref_pass(cond, mf1) : mq1;
        expq.push_back(mk(mf0, c0));
        expq.push_back(mk(mf1, c1));
    endtask

    task automatic tick();
        logic c0, c1, p1;
        c0 = ref_pass(cond, mf0);
        p1 = ref_pass(cond, mf1);
        c1 = instr_start ? p1 : mq1;
        @(posedge clk);
        if (!reset_n) begin
            mf0 = '0; mf1 = '0; mq1 = 1'b0;
        end else begin
            if (flag_w[1] & c0) mf0[3:2] = alu_flags[3:2];
            if (flag_w[0] & c0) mf0[1:0] = alu_flags[1:0];
            if (flag_w[1] & c1) mf1[3:2] = alu_flags[3:2];
            if (flag_w[0] & c1) mf1[1:0] = alu_flags[1:0];
            if (instr_start) mq1 = p1;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        drive('0);
        reset_n = 1'b0;
        mf0 = '0; mf1 = '0; mq1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        stim_t v[4];
        obs_t  e;
        v = '{'{4'hE, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
              '{4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
              '{4'h1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
              '{4'h1, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
        apply_reset();
        checks++;
        if (fl0 !== 4'b0000 || fl1 !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b/%b, expected 0000", fl0, fl1);
        end
        foreach (v[i]) begin
            drive(v[i]); #1; push_expect();
            e = expq.pop_front(); checks++;
            if (obs0 !== e) begin errors++; $display("[TB] FAIL reset[%0d] single: got %b, expected %b", i, obs0, e); end
            e = expq.pop_front(); checks++;
            if (obs1 !== e) begin errors++; $display("[TB] FAIL reset[%0d] multi: got %b, expected %b", i, obs1, e); end
            tick();
        end
        checks++;
        if ({pc1, rw1, mw1} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_multi_gated: got %b, expected 000", {pc1, rw1, mw1});
        end
    endtask

    task automatic test_flag_set();
        stim_t v[4];
        obs_t  e;
        v = '{'{4'hE, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'h0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
              '{4'h1, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
              '{4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        foreach (v[i]) begin
            drive(v[i]); #1; push_expect();
            e = expq.pop_front(); checks++;
            if (obs0 !== e) begin errors++; $display("[TB] FAIL flag_set[%0d] single: got %b, expected %b", i, obs0, e); end
            e = expq.pop_front(); checks++;
            if (obs1 !== e) begin errors++; $display("[TB] FAIL flag_set[%0d] multi: got %b, expected %b", i, obs1, e); end
            if (i == 1) begin
                checks++;
                if (mw0 !== 1'b1 || fl0 !== 4'b0100) begin
                    errors++;
                    $display("[TB] FAIL eq_after_zero: got mem_write=%b flags=%b, expected 1 0100", mw0, fl0);
                end
            end
            tick();
        end
    endtask

    task automatic test_signed_conds();
        stim_t v[11];
        obs_t  e;
        v = '{'{4'hE, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'hA, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'hE, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'hA, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'hB, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'hE, 4'b0010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'h8, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'hE, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'h9, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'hC, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'hD, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        foreach (v[i]) begin
            drive(v[i]); #1; push_expect();
            e = expq.pop_front(); checks++;
            if (obs0 !== e) begin errors++; $display("[TB] FAIL signed[%0d] single: got %b, expected %b", i, obs0, e); end
            e = expq.pop_front(); checks++;
            if (obs1 !== e) begin errors++; $display("[TB] FAIL signed[%0d] multi: got %b, expected %b", i, obs1, e); end
            tick();
        end
    endtask

    task automatic test_fail_hold();
        stim_t v[5];
        obs_t  e;
        v = '{'{4'hE, 4'b0101, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'h1, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'h0, 4'b1010, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        foreach (v[i]) begin
            drive(v[i]); #1; push_expect();
            e = expq.pop_front(); checks++;
            if (obs0 !== e) begin errors++; $display("[TB] FAIL fail_hold[%0d] single: got %b, expected %b", i, obs0, e); end
            e = expq.pop_front(); checks++;
            if (obs1 !== e) begin errors++; $display("[TB] FAIL fail_hold[%0d] multi: got %b, expected %b", i, obs1, e); end
            tick();
        end
        checks++;
        if (fl0 !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL nz_only_write: got %b, expected 1001", fl0);
        end
    endtask

    task automatic test_cmp_nv();
        stim_t v[3];
        obs_t  e;
        v = '{'{4'hE, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
              '{4'hF, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
              '{4'hE, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
        foreach (v[i]) begin
            drive(v[i]); #1; push_expect();
            e = expq.pop_front(); checks++;
            if (obs0 !== e) begin errors++; $display("[TB] FAIL cmp_nv[%0d] single: got %b, expected %b", i, obs0, e); end
            e = expq.pop_front(); checks++;
            if (obs1 !== e) begin errors++; $display("[TB] FAIL cmp_nv[%0d] multi: got %b, expected %b", i, obs1, e); end
            tick();
        end
        checks++;
        if (fl0 !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL cmp_flags: got %b, expected 0110", fl0);
        end
    endtask

    task automatic test_multicycle();
        stim_t v[6];
        logic  exp_pc1[6];
        obs_t  e;
        v = '{'{4'hE, 4'b0100, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
              '{4'h0, 4'b0000, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
              '{4'h0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'h1, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
              '{4'h0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
              '{4'h0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        exp_pc1 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        apply_reset();
        foreach (v[i]) begin
            drive(v[i]); #1; push_expect();
            e = expq.pop_front(); checks++;
            if (obs0 !== e) begin errors++; $display("[TB] FAIL multicycle[%0d] single: got %b, expected %b", i, obs0, e); end
            e = expq.pop_front(); checks++;
            if (obs1 !== e || pc1 !== exp_pc1[i]) begin
                errors++;
                $display("[TB] FAIL multicycle[%0d] multi: got %b, expected %b (pc_src %b)", i, obs1, e, exp_pc1[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drive('{4'hE, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
        #2 reset_n = 1'b0;
        tick();
        checks++;
        if (fl0 !== 4'b0000 || fl1 !== 4'b0000 || pc1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid: got flags %b/%b pc_src %b, expected 0000/0000 1", fl0, fl1, pc1);
        end
        drive('0);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        stim_t       s;
        logic [14:0] rv;
        obs_t        e;
        for (int i = 0; i < 60; i++) begin
            rv = 15'($urandom);
            s  = rv;
            s.st = ($urandom_range(0, 3) == 0);
            drive(s); #1; push_expect();
            e = expq.pop_front(); checks++;
            if (obs0 !== e) begin errors++; $display("[TB] FAIL random[%0d] single: got %b, expected %b", i, obs0, e); end
            e = expq.pop_front(); checks++;
            if (obs1 !== e) begin errors++; $display("[TB] FAIL random[%0d] multi: got %b, expected %b", i, obs1, e); end
            tick();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive('0);
        mf0 = '0; mf1 = '0; mq1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_flag_set();
        test_signed_conds();
        test_fail_hold();
        test_cmp_nv();
        test_multicycle();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
